// File: rtl/ferry_move_sequencer.sv
// River-crossing move sequencer: checks cargo requests against bank/safety rules and strobes legal trips.
// Latency: response (trip+strobe or err) one cycle after handshake; busy TRIP_CYCLES cycles per trip.
// Backpressure: req_ready high only in IDLE; requests while busy are ignored, not queued.
// Optional: FERRY_AUTO_SOLVE_EN adds a start input that plays the built-in 7-trip solution.
module ferry_move_sequencer #(
  parameter int TRIP_CYCLES = 1,
  parameter int CNT_W       = 8,
  parameter int MAX_MOVES   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FERRY_AUTO_SOLVE_EN
  input  logic             start,
`endif
  input  logic             req_valid,
  input  logic [1:0]       req_cargo,
  output logic             req_ready,
  output logic             w,
  output logic             g,
  output logic             c,
  output logic             trip,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [3:0]       bank,
  output logic [CNT_W-1:0] move_cnt,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_CROSS, S_DONE, S_FAIL} state_t;

  localparam int TW = (TRIP_CYCLES > 1) ? $clog2(TRIP_CYCLES) : 1;

  state_t           r_state;
  logic [TW-1:0]    r_tcnt;
  logic [3:0]       r_bank;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_code;
  logic             r_w, r_g, r_c, r_trip, r_err, r_done;

  logic             w_req_vld;
  logic [1:0]       w_req_cargo;
  logic             w_take;
  logic             w_m, w_sel_bit, w_loc_bad, w_unsafe, w_limit;
  logic             w_wolf_rem, w_goat_rem, w_cab_rem;
  logic [1:0]       w_code;
  logic [3:0]       w_next_bank;

`ifdef FERRY_AUTO_SOLVE_EN
  logic       r_auto;
  logic [2:0] r_step;
  logic [1:0] w_rom;
  logic       w_start_hit;

  always_comb begin
    case (r_step)
      3'd0:    w_rom = 2'd2;
      3'd1:    w_rom = 2'd0;
      3'd2:    w_rom = 2'd1;
      3'd3:    w_rom = 2'd2;
      3'd4:    w_rom = 2'd3;
      3'd5:    w_rom = 2'd0;
      default: w_rom = 2'd2;
    endcase
  end

  assign w_start_hit = start && (r_state == S_IDLE) && (r_cnt == '0) && !r_auto;
  assign w_req_vld   = r_auto ? 1'b1 : (req_valid && !w_start_hit);
  assign w_req_cargo = r_auto ? w_rom : req_cargo;

  // Playback aborts on any reject so a bad ROM can never loop on errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto <= 1'b0;
      r_step <= '0;
    end else if (w_start_hit) begin
      r_auto <= 1'b1;
      r_step <= '0;
    end else if (r_auto && w_take) begin
      if (w_code != 2'd0 || r_step == 3'd6) r_auto <= 1'b0;
      else                                  r_step <= r_step + 3'd1;
    end
  end
`else
  assign w_req_vld   = req_valid;
  assign w_req_cargo = req_cargo;
`endif

  assign w_take = w_req_vld && (r_state == S_IDLE);
  assign w_m    = r_bank[3];

  always_comb begin
    case (w_req_cargo)
      2'd1:    w_sel_bit = r_bank[0];
      2'd2:    w_sel_bit = r_bank[1];
      2'd3:    w_sel_bit = r_bank[2];
      default: w_sel_bit = w_m;
    endcase
  end

  // Safety looks at the bank the boatman is leaving, minus whatever he takes.
  assign w_loc_bad  = (w_req_cargo != 2'd0) && (w_sel_bit != w_m);
  assign w_wolf_rem = (r_bank[0] == w_m) && (w_req_cargo != 2'd1);
  assign w_goat_rem = (r_bank[1] == w_m) && (w_req_cargo != 2'd2);
  assign w_cab_rem  = (r_bank[2] == w_m) && (w_req_cargo != 2'd3);
  assign w_unsafe   = w_goat_rem && (w_wolf_rem || w_cab_rem);
  assign w_limit    = (MAX_MOVES != 0) && (32'(r_cnt) == 32'(MAX_MOVES));
  assign w_code     = w_limit ? 2'd3 : w_loc_bad ? 2'd1 : w_unsafe ? 2'd2 : 2'd0;

  always_comb begin
    w_next_bank    = r_bank;
    w_next_bank[3] = ~w_m;
    case (w_req_cargo)
      2'd1:    w_next_bank[0] = ~w_m;
      2'd2:    w_next_bank[1] = ~w_m;
      2'd3:    w_next_bank[2] = ~w_m;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bank  <= '0;
      r_cnt   <= '0;
      r_code  <= 2'd0;
      r_w     <= 1'b0;
      r_g     <= 1'b0;
      r_c     <= 1'b0;
      r_trip  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_w    <= 1'b0;
      r_g    <= 1'b0;
      r_c    <= 1'b0;
      r_trip <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            if (w_code == 2'd0) begin
              r_trip  <= 1'b1;
              r_w     <= (w_req_cargo == 2'd1);
              r_g     <= (w_req_cargo == 2'd2);
              r_c     <= (w_req_cargo == 2'd3);
              r_bank  <= w_next_bank;
              r_cnt   <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
              r_code  <= 2'd0;
              r_tcnt  <= TW'(TRIP_CYCLES - 1);
              r_state <= S_CROSS;
            end else begin
              r_err  <= 1'b1;
              r_code <= w_code;
              if (w_code == 2'd3) r_state <= S_FAIL;
            end
          end
        end
        S_CROSS: begin
          if (r_tcnt == '0) begin
            if (r_bank == 4'hF) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_tcnt <= r_tcnt - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign w         = r_w;
  assign g         = r_g;
  assign c         = r_c;
  assign trip      = r_trip;
  assign err       = r_err;
  assign err_code  = r_code;
  assign bank      = r_bank;
  assign move_cnt  = r_cnt;
  assign done      = r_done;

endmodule

// File: tb/tb_ferry_move_sequencer.sv
// Directed bench: four sequencer instances with different TRIP_CYCLES/MAX_MOVES settings.
module tb_ferry_move_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_n, vld, rdy, sw, sg, sc, trp, ser, dn;
  logic [1:0]   cargo [N];
  logic [1:0]   code  [N];
  logic [3:0]   bk    [N];
  logic [7:0]   cnt   [N];

  int tests = 0;
  int fails = 0;

  // u0: TRIP 1 / limit 15, u1: TRIP 3 / limit 2, u2: TRIP 4, u3: unlimited moves
  for (genvar i = 0; i < N; i++) begin : g_dut
    ferry_move_sequencer #(
      .TRIP_CYCLES(i == 1 ? 3 : (i == 2 ? 4 : 1)),
      .CNT_W      (8),
      .MAX_MOVES  (i == 1 ? 2 : (i == 3 ? 0 : 15))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[i]),
      .req_valid(vld[i]),
      .req_cargo(cargo[i]),
      .req_ready(rdy[i]),
      .w        (sw[i]),
      .g        (sg[i]),
      .c        (sc[i]),
      .trip     (trp[i]),
      .err      (ser[i]),
      .err_code (code[i]),
      .bank     (bk[i]),
      .move_cnt (cnt[i]),
      .done     (dn[i])
    );
  end

  typedef struct {
    logic [1:0] cargo;
    logic       trip, w, g, c, err;
    logic [1:0] code;
    logic [3:0] bank;
    logic [7:0] cnt;
    logic       rdy, done;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input int d, input string tag, input vec_t e);
    chk({tag, ".trip"}, 32'(trp[d]), 32'(e.trip));
    chk({tag, ".w"},    32'(sw[d]),  32'(e.w));
    chk({tag, ".g"},    32'(sg[d]),  32'(e.g));
    chk({tag, ".c"},    32'(sc[d]),  32'(e.c));
    chk({tag, ".err"},  32'(ser[d]), 32'(e.err));
    chk({tag, ".code"}, 32'(code[d]), 32'(e.code));
    chk({tag, ".bank"}, 32'(bk[d]),  32'(e.bank));
    chk({tag, ".cnt"},  32'(cnt[d]), 32'(e.cnt));
    chk({tag, ".rdy"},  32'(rdy[d]), 32'(e.rdy));
    chk({tag, ".done"}, 32'(dn[d]),  32'(e.done));
  endtask

  // Returns at the negedge of the response cycle, valid already dropped.
  task automatic req(input int d, input logic [1:0] cg);
    int k;
    @(negedge clk);
    vld[d]   = 1'b1;
    cargo[d] = cg;
    k = 0;
    while (!rdy[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!rdy[d]) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: dut %0d ready never rose within 40 cycles", d);
    end
    @(posedge clk);
    @(negedge clk);
    vld[d] = 1'b0;
  endtask

  vec_t tbl [9];
  vec_t e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // cargo, trip, w, g, c, err, code, bank{m,c,g,w}, cnt, rdy, done
    tbl[0] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 8'd0, 1'b1, 1'b0};
    tbl[1] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 8'd1, 1'b0, 1'b0};
    tbl[2] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 8'd2, 1'b0, 1'b0};
    tbl[3] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 8'd2, 1'b1, 1'b0};
    tbl[4] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1011, 8'd3, 1'b0, 1'b0};
    tbl[5] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 8'd4, 1'b0, 1'b0};
    tbl[6] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1101, 8'd5, 1'b0, 1'b0};
    tbl[7] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0101, 8'd6, 1'b0, 1'b0};
    tbl[8] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 8'd7, 1'b0, 1'b0};

    rst_n = '0;
    vld   = '0;
    for (int i = 0; i < N; i++) cargo[i] = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    @(negedge clk);

    e = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 8'd0, 1'b1, 1'b0};
    for (int d = 0; d < N; d++) chk_vec(d, $sformatf("reset%0d", d), e);

    // Solution path with an unsafe and a wrong-bank reject mixed in.
    for (int i = 0; i < 9; i++) begin
      req(0, tbl[i].cargo);
      chk_vec(0, $sformatf("vec%0d", i), tbl[i]);
    end
    @(negedge clk);
    chk("done_high", 32'(dn[0]), 32'd1);
    chk("done_rdy", 32'(rdy[0]), 32'd0);
    vld[0] = 1'b1;
    cargo[0] = 2'd2;
    repeat (3) begin
      @(negedge clk);
      chk("done_ignore_trip", 32'(trp[0]), 32'd0);
      chk("done_hold", 32'(dn[0]), 32'd1);
    end
    vld[0] = 1'b0;
    chk("done_cnt", 32'(cnt[0]), 32'd7);

    // TRIP_CYCLES=3 latency, then move limit 2.
    req(1, 2'd2);
    e = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 8'd1, 1'b0, 1'b0};
    chk_vec(1, "lat_c1", e);
    vld[1] = 1'b1;
    cargo[1] = 2'd0;
    @(negedge clk);
    chk("lat_c2_rdy", 32'(rdy[1]), 32'd0);
    chk("lat_c2_g", 32'(sg[1]), 32'd0);
    @(negedge clk);
    chk("lat_c3_rdy", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    chk("lat_c4_rdy", 32'(rdy[1]), 32'd1);
    chk("lat_c4_trip", 32'(trp[1]), 32'd0);
    @(negedge clk);
    vld[1] = 1'b0;
    e = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 8'd2, 1'b0, 1'b0};
    chk_vec(1, "lat_c5", e);
    req(1, 2'd1);
    e = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0010, 8'd2, 1'b0, 1'b0};
    chk_vec(1, "limit", e);
    vld[1] = 1'b1;
    repeat (5) @(negedge clk);
    vld[1] = 1'b0;
    e = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 8'd2, 1'b0, 1'b0};
    chk_vec(1, "fail_hold", e);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    e = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 8'd0, 1'b1, 1'b0};
    chk_vec(1, "fail_reset", e);

    // Asynchronous reset in cycle 2 of a 4-cycle trip.
    req(2, 2'd2);
    chk("abort_c1_trip", 32'(trp[2]), 32'd1);
    @(posedge clk);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("abort_bank", 32'(bk[2]), 32'd0);
    chk("abort_cnt", 32'(cnt[2]), 32'd0);
    chk("abort_trip", 32'(trp[2]), 32'd0);
    chk("abort_g", 32'(sg[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    chk("abort_rdy", 32'(rdy[2]), 32'd1);
    req(2, 2'd2);
    e = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 8'd1, 1'b0, 1'b0};
    chk_vec(2, "abort_retry", e);

    // Goat shuttles back and forth; counter must stick at 255.
    for (int i = 1; i <= 257; i++) begin
      req(3, 2'd2);
      chk($sformatf("sat_trip%0d", i), 32'(trp[3]), 32'd1);
      chk($sformatf("sat_cnt%0d", i), 32'(cnt[3]), (i > 255) ? 32'd255 : 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
